// File: rtl/motion_update_broadcaster.sv
// motion_update_broadcaster
//   Transmit side of the motion-update broadcast bus. On start it walks every
//   cell (z fastest, then y, then x), reads the particle count (address 0) and
//   then each particle (addresses 1..count). It adds the displacement, wraps the
//   result periodically and broadcasts {data, dst_cell, valid} while
//   motion_update_enable is high. Enable then drops for three cycles so that
//   every cache commits its count and swaps buffers. After that, done pulses.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 1-cycle pulse, accepted only when idle
//   out_rd_cell           {x,y,z} of the cache being read (0 when not reading)
//   out_rd_address        read address, out_rden read enable
//   in_pos, in_disp       {z,y,x} readout, one cycle after out_rden
//   motion_update_enable  broadcast window
//   out_data              {z,y,x} wrapped position
//   out_data_dst_cell     {x,y,z} destination cell
//   out_data_valid        qualifies out_data/out_data_dst_cell
//   busy, done            sweep in progress / end-of-sweep pulse
module motion_update_broadcaster #(
    parameter int DATA_WIDTH    = 32,
    parameter int OFFSET_WIDTH  = 24,
    parameter int ADDR_WIDTH    = 8,
    parameter int PARTICLE_NUM  = 220,
    parameter int CELL_ID_WIDTH = 4,
    parameter int NUM_CELL_X    = 3,
    parameter int NUM_CELL_Y    = 4,
    parameter int NUM_CELL_Z    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
    output logic [ADDR_WIDTH-1:0]      out_rd_address,
    output logic                       out_rden,
    input  logic [3*DATA_WIDTH-1:0]    in_pos,
    input  logic [3*DATA_WIDTH-1:0]    in_disp,
    output logic                       motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]    out_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
    output logic                       out_data_valid,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, HOLD_LOW} state_t;

    localparam logic [ADDR_WIDTH-1:0]    MAX_CNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CELL_ID_WIDTH-1:0] CID_ONE  = CELL_ID_WIDTH'(1);
    localparam logic [CELL_ID_WIDTH-1:0] NX       = CELL_ID_WIDTH'(NUM_CELL_X);
    localparam logic [CELL_ID_WIDTH-1:0] NY       = CELL_ID_WIDTH'(NUM_CELL_Y);
    localparam logic [CELL_ID_WIDTH-1:0] NZ       = CELL_ID_WIDTH'(NUM_CELL_Z);

    state_t                    state, state_nxt;
    logic [CELL_ID_WIDTH-1:0]  cell_x, cell_y, cell_z;
    logic [ADDR_WIDTH-1:0]     cnt, idx, sat_cnt;
    logic [1:0]                hold_cnt;
    logic [2:1]                vld_pipe;   // [1]: readout on in_pos, [2]: out regs
    logic                      stream_rd, cell_adv, last_cell;
    logic [DATA_WIDTH-1:0]     wx, wy, wz;

    // Bring a coordinate that stepped one cell outside 1..num back inside.
    function automatic logic [DATA_WIDTH-1:0] wrap_coord(
        input logic [DATA_WIDTH-1:0] p, input logic [DATA_WIDTH-1:0] d, input int num);
        logic [DATA_WIDTH-1:0]              s, span;
        logic [DATA_WIDTH-OFFSET_WIDTH-1:0] ip;
        s    = p + d;
        span = DATA_WIDTH'(num) << OFFSET_WIDTH;
        ip   = s[DATA_WIDTH-1:OFFSET_WIDTH];
        if (ip == '0)
            s = s + span;
        else if (ip == (DATA_WIDTH-OFFSET_WIDTH)'(num + 1))
            s = s - span;
        return s;
    endfunction

    assign sat_cnt   = (in_pos[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : in_pos[ADDR_WIDTH-1:0];
    assign last_cell = (cell_x == NX) && (cell_y == NY) && (cell_z == NZ);
    assign busy      = (state != IDLE);
    // Cell select only meaningful while reading; keep it quiet otherwise.
    assign out_rd_cell    = out_rden ? {cell_x, cell_y, cell_z} : '0;
    assign out_data_valid = vld_pipe[2];

    assign wx = wrap_coord(in_pos[DATA_WIDTH-1:0],              in_disp[DATA_WIDTH-1:0],              NUM_CELL_X);
    assign wy = wrap_coord(in_pos[2*DATA_WIDTH-1:DATA_WIDTH],   in_disp[2*DATA_WIDTH-1:DATA_WIDTH],   NUM_CELL_Y);
    assign wz = wrap_coord(in_pos[3*DATA_WIDTH-1:2*DATA_WIDTH], in_disp[3*DATA_WIDTH-1:2*DATA_WIDTH], NUM_CELL_Z);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt            = state;
        out_rden             = 1'b0;
        out_rd_address       = '0;
        motion_update_enable = 1'b0;
        stream_rd            = 1'b0;
        cell_adv             = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RD_CNT;
            RD_CNT: begin
                out_rden             = 1'b1;
                motion_update_enable = 1'b1;
                state_nxt            = WAIT_CNT;
            end
            WAIT_CNT: begin
                motion_update_enable = 1'b1;
                if (sat_cnt == '0) begin
                    cell_adv  = 1'b1;
                    state_nxt = last_cell ? DRAIN : RD_CNT;
                end else begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                out_rden             = 1'b1;
                out_rd_address       = idx;
                motion_update_enable = 1'b1;
                stream_rd            = 1'b1;
                if (idx == cnt) begin
                    cell_adv  = 1'b1;
                    state_nxt = last_cell ? DRAIN : RD_CNT;
                end
            end
            DRAIN: begin
                // Enable covers the final valid, which lands the cycle after
                // the readout stage empties.
                motion_update_enable = 1'b1;
                if (!vld_pipe[1]) state_nxt = HOLD_LOW;
            end
            HOLD_LOW: if (hold_cnt == 2'd2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_x            <= CID_ONE;
            cell_y            <= CID_ONE;
            cell_z            <= CID_ONE;
            cnt               <= '0;
            idx               <= '0;
            hold_cnt          <= '0;
            vld_pipe          <= '0;
            done              <= 1'b0;
            out_data          <= '0;
            out_data_dst_cell <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], stream_rd};
            done     <= (state == HOLD_LOW) && (hold_cnt == 2'd2);
            hold_cnt <= (state == HOLD_LOW) ? hold_cnt + 2'd1 : 2'd0;

            if (state == WAIT_CNT) begin
                cnt <= sat_cnt;
                idx <= ADDR_ONE;
            end else if (stream_rd) begin
                idx <= idx + ADDR_ONE;
            end

            // z fastest; wrapping past the last cell leaves all three at 1.
            if (cell_adv) begin
                if (cell_z == NZ) begin
                    cell_z <= CID_ONE;
                    if (cell_y == NY) begin
                        cell_y <= CID_ONE;
                        cell_x <= (cell_x == NX) ? CID_ONE : cell_x + CID_ONE;
                    end else begin
                        cell_y <= cell_y + CID_ONE;
                    end
                end else begin
                    cell_z <= cell_z + CID_ONE;
                end
            end

            if (vld_pipe[1]) begin
                out_data          <= {wz, wy, wx};
                out_data_dst_cell <= {wx[OFFSET_WIDTH +: CELL_ID_WIDTH],
                                      wy[OFFSET_WIDTH +: CELL_ID_WIDTH],
                                      wz[OFFSET_WIDTH +: CELL_ID_WIDTH]};
            end else begin
                out_data          <= '0;
                out_data_dst_cell <= '0;
            end
        end
    end

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// Bench for motion_update_broadcaster: registered cache-array model, reference
// queue of expected broadcasts (with expected cycle of each valid), sweep runner.
module tb_motion_update_broadcaster;
    localparam int DW = 32, AW = 8, CW = 4, NCELL = 24, MAXP = 219;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3*CW-1:0] out_rd_cell, out_data_dst_cell;
    logic [AW-1:0]   out_rd_address;
    logic            out_rden, motion_update_enable, out_data_valid, busy, done;
    logic [3*DW-1:0] in_pos = '0, in_disp = '0, out_data;

    int errs = 0, checks = 0;
    int scan_end, last_n;

    logic [7:0]      cnt_mem  [NCELL];
    logic [3*DW-1:0] pos_mem  [NCELL][MAXP+1];
    logic [3*DW-1:0] disp_mem [NCELL][MAXP+1];

    typedef struct { logic [3*DW-1:0] data; logic [3*CW-1:0] dst; int cyc; } exp_t;
    exp_t exp_q[$];

    motion_update_broadcaster dut (
        .clk(clk), .rst(rst), .start(start),
        .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rden(out_rden),
        .in_pos(in_pos), .in_disp(in_disp),
        .motion_update_enable(motion_update_enable), .out_data(out_data),
        .out_data_dst_cell(out_data_dst_cell), .out_data_valid(out_data_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int cidx(input logic [3*CW-1:0] c);
        int x = int'(c[11:8]);
        int y = int'(c[7:4]);
        int z = int'(c[3:0]);
        if (x < 1 || x > 3 || y < 1 || y > 4 || z < 1 || z > 2) return 0;
        return ((x-1)*4 + (y-1))*2 + (z-1);
    endfunction

    function automatic logic [3*DW-1:0] rd_word(input logic [3*CW-1:0] c,
                                                 input logic [AW-1:0] a, input bit is_disp);
        int ci = cidx(c);
        logic [3*DW-1:0] w;
        w = '0;
        if (a == '0) begin
            if (!is_disp) w = {{(3*DW-8){1'b0}}, cnt_mem[ci]};
        end else if (int'(a) <= MAXP) begin
            w = is_disp ? disp_mem[ci][a] : pos_mem[ci][a];
        end
        return w;
    endfunction

    // Per-cell caches behind the read mux: one-cycle registered readout.
    always @(posedge clk) begin
        if (out_rden) begin
            in_pos  <= rd_word(out_rd_cell, out_rd_address, 1'b0);
            in_disp <= rd_word(out_rd_cell, out_rd_address, 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Periodic box of num cells starting at 1: new = ((p-1+d) mod num) + 1.
    function automatic logic [DW-1:0] ref_coord(input logic [DW-1:0] p, input logic [DW-1:0] d, input int num);
        longint one  = longint'(1) << 24;
        longint span = longint'(num) * one;
        longint u    = longint'(p) - one + longint'($signed(d));
        u = u % span;
        if (u < 0) u += span;
        return DW'(u + one);
    endfunction

    function automatic logic [DW-1:0] rnd_pos(input int c);
        return {8'(c), 24'($urandom)};
    endfunction

    function automatic logic [DW-1:0] rnd_disp();
        int d = int'($urandom_range(0, 33554430)) - 16777215;
        return DW'(d);
    endfunction

    task automatic fill(input int maxcnt);
        for (int ci = 0; ci < NCELL; ci++) begin
            int x = ci/8 + 1;
            int y = (ci/2)%4 + 1;
            int z = ci%2 + 1;
            cnt_mem[ci] = 8'($urandom_range(0, maxcnt));
            for (int a = 0; a <= MAXP; a++) begin
                pos_mem[ci][a]  = {rnd_pos(z), rnd_pos(y), rnd_pos(x)};
                disp_mem[ci][a] = {rnd_disp(), rnd_disp(), rnd_disp()};
            end
        end
    endtask

    task automatic clear_cnts();
        for (int ci = 0; ci < NCELL; ci++) cnt_mem[ci] = '0;
    endtask

    // Expected broadcasts in sweep order. Cycle 1 = first cycle after start is
    // taken; each cell costs 2 cycles plus one per particle, and a particle
    // read in cycle t is broadcast in t+2.
    task automatic build_exp();
        int c = 1;
        exp_q.delete();
        last_n = 0;
        for (int x = 1; x <= 3; x++)
            for (int y = 1; y <= 4; y++)
                for (int z = 1; z <= 2; z++) begin
                    int ci = ((x-1)*4 + (y-1))*2 + (z-1);
                    int n  = (int'(cnt_mem[ci]) > MAXP) ? MAXP : int'(cnt_mem[ci]);
                    for (int k = 1; k <= n; k++) begin
                        exp_t e;
                        logic [DW-1:0] nx, ny, nz;
                        nx = ref_coord(pos_mem[ci][k][DW-1:0],      disp_mem[ci][k][DW-1:0],      3);
                        ny = ref_coord(pos_mem[ci][k][2*DW-1:DW],   disp_mem[ci][k][2*DW-1:DW],   4);
                        nz = ref_coord(pos_mem[ci][k][3*DW-1:2*DW], disp_mem[ci][k][3*DW-1:2*DW], 2);
                        e.data = {nz, ny, nx};
                        e.dst  = {nx[27:24], ny[27:24], nz[27:24]};
                        e.cyc  = c + 3 + k;
                        exp_q.push_back(e);
                    end
                    last_n = n;
                    c += 2 + n;
                end
        scan_end = c - 1;
    endtask

    task automatic run_sweep(input string tag, input int abort_cyc, input bit poke);
        int cyc = 1, last_v = 0, fall = -1, done_c = -1, nval = 0, total;
        int bad_en = 0, bad_busy = 0, bad_zero = 0, bad_extra = 0;
        exp_t e;
        build_exp();
        total = exp_q.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_rise"}, {motion_update_enable, busy}, 2'b11);
        while (done_c < 0 && cyc < 12000) begin
            if (cyc == abort_cyc) begin
                rst = 1'b1;
                @(negedge clk);
                chk({tag, "_abort_ctl"}, {motion_update_enable, out_data_valid, busy, out_rden, done,
                                          out_rd_cell, out_rd_address}, '0);
                chk({tag, "_abort_data"}, {out_data_dst_cell, out_data}, '0);
                rst = 1'b0;
                return;
            end
            if (out_data_valid) begin
                if (!motion_update_enable) bad_en++;
                if (exp_q.size() == 0) bad_extra++;
                else begin
                    e = exp_q.pop_front();
                    chk({tag, "_data"}, out_data, e.data);
                    chk({tag, "_dst"}, out_data_dst_cell, e.dst);
                    chk({tag, "_cyc"}, cyc, e.cyc);
                end
                last_v = cyc;
                nval++;
            end else if (out_data != '0 || out_data_dst_cell != '0) bad_zero++;
            if (done) done_c = cyc;
            else if (!busy) bad_busy++;
            if (fall < 0 && !motion_update_enable) fall = cyc;
            else if (fall >= 0 && motion_update_enable) bad_en++;
            start = poke && (cyc == 2);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, done_c >= 0, 1'b1);
        chk({tag, "_nvalid"}, nval, total);
        chk({tag, "_extra"}, bad_extra, 0);
        if (total > 0 && last_n > 0) chk({tag, "_fall"}, fall, last_v + 1);
        else chk({tag, "_fall_win"}, (fall > scan_end) && (fall <= scan_end + 3) && (fall > last_v), 1'b1);
        chk({tag, "_done_gap"}, done_c, fall + 3);
        chk({tag, "_en_rules"}, bad_en, 0);
        chk({tag, "_busy"}, bad_busy, 0);
        chk({tag, "_zero_idle"}, bad_zero, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {done, busy, motion_update_enable}, 3'b000);
    endtask

    initial begin
        fill(0);
        repeat (3) @(negedge clk);
        chk("reset_ctl", {motion_update_enable, out_data_valid, busy, out_rden, done,
                          out_rd_cell, out_rd_address}, '0);
        chk("reset_data", {out_data_dst_cell, out_data}, '0);
        rst = 1'b0;

        // rst and start together: rst wins
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        chk("rst_wins", {busy, motion_update_enable}, 2'b00);
        @(negedge clk);
        chk("rst_wins_hold", {busy, motion_update_enable}, 2'b00);

        // single cell (1,1,1), two stationary particles
        clear_cnts();
        cnt_mem[0] = 8'd2;
        for (int k = 1; k <= 2; k++) begin
            pos_mem[0][k]  = {32'h0180_0000, 32'h0180_0000, 32'h0180_0000};
            disp_mem[0][k] = '0;
        end
        run_sweep("one_cell", 0, 1'b0);

        // low wrap on x, in last cell so enable falls right after the valid
        clear_cnts();
        cnt_mem[23]     = 8'd1;
        pos_mem[23][1]  = {32'h0280_0000, 32'h0480_0000, 32'h0180_0000};
        disp_mem[23][1] = {32'h0, 32'h0, 32'hFF40_0000};
        run_sweep("low_wrap", 0, 1'b0);

        // high wrap on x, cell (3,2,1), y/z move without wrapping
        clear_cnts();
        cnt_mem[18]     = 8'd1;
        pos_mem[18][1]  = {32'h0110_0000, 32'h0280_0000, 32'h03E0_0000};
        disp_mem[18][1] = {32'hFFF0_0000, 32'h0010_0000, 32'h0040_0000};
        run_sweep("high_wrap", 0, 1'b0);

        clear_cnts();
        run_sweep("empty", 0, 1'b0);

        // saturation plus back-to-back cells
        fill(0);
        cnt_mem[0] = 8'd255;
        cnt_mem[1] = 8'd3;
        run_sweep("saturate", 0, 1'b0);

        // reset during STREAM, then a clean sweep
        clear_cnts();
        cnt_mem[0] = 8'd50;
        run_sweep("abort", 20, 1'b0);
        run_sweep("after_abort", 0, 1'b0);

        fill(6);
        run_sweep("rand0_poke", 0, 1'b1);
        fill(6);
        run_sweep("rand1", 0, 1'b0);
        fill(3);
        run_sweep("rand2", 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
